// File: rtl/exc_pkg.sv
// Shared definitions for the CP0 exception/interrupt controller: cause codes,
// FSM state encoding and the default handler fetch address.
package exc_pkg;

  localparam logic [2:0] CAUSE_INT0 = 3'd0;
  localparam logic [2:0] CAUSE_INT1 = 3'd1;
  localparam logic [2:0] CAUSE_INT2 = 3'd2;
  localparam logic [2:0] CAUSE_OV   = 3'd3;
  localparam logic [2:0] CAUSE_SYS  = 3'd4;
  localparam logic [2:0] CAUSE_RI   = 3'd5;

  localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_4180;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StEnter   = 2'd1,
    StHandler = 2'd2,
    StLeave   = 2'd3
  } exc_state_e;

  function automatic logic is_int_code(input logic [2:0] code);
    return code <= CAUSE_INT2;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: RI > OV > SYS > INT0 > INT1 > INT2.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic       ri_i,
  input  logic       ov_i,
  input  logic       sys_i,
  input  logic [2:0] pend_i,
  output logic       valid_o,
  output logic [2:0] code_o
);

  always_comb begin
    valid_o = ri_i | ov_i | sys_i | (|pend_i);
    code_o  = CAUSE_INT0;
    if (ri_i) begin
      code_o = CAUSE_RI;
    end else if (ov_i) begin
      code_o = CAUSE_OV;
    end else if (sys_i) begin
      code_o = CAUSE_SYS;
    end else if (pend_i[0]) begin
      code_o = CAUSE_INT0;
    end else if (pend_i[1]) begin
      code_o = CAUSE_INT1;
    end else if (pend_i[2]) begin
      code_o = CAUSE_INT2;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// CP0 exception/interrupt controller: prioritises events, saves EPC, redirects
// fetch to the handler and back on eret. EXC_INT_EDGE_EN selects edge-triggered interrupts.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = DEFAULT_HANDLER_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] pc_in,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        exc_sys,
  input  logic        eret,
  input  logic [2:0]  int_req,
  output logic        cause_we,
  output logic [2:0]  cause_code,
  output logic        epc_we,
  output logic [31:0] epc_out,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        in_handler
);

  exc_state_e  state_q, state_d;
  logic [2:0]  pend_q, pend_d, pend_set, pend_clr;
  logic [2:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] rpc_q, rpc_d;
  logic        cause_we_q, epc_we_q, flush_q, redirect_q, in_handler_q;
  logic        enc_valid;
  logic [2:0]  enc_code;

  exc_prio_enc u_prio_enc (
    .ri_i    (exc_ri),
    .ov_i    (exc_ov),
    .sys_i   (exc_sys),
    .pend_i  (pend_q),
    .valid_o (enc_valid),
    .code_o  (enc_code)
  );

`ifdef EXC_INT_EDGE_EN
  logic [2:0] int_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_q <= 3'b000;
    end else begin
      int_q <= int_req;
    end
  end

  assign pend_set = int_req & ~int_q;
`else
  assign pend_set = int_req;
`endif

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    epc_d    = epc_q;
    rpc_d    = rpc_q;
    pend_clr = 3'b000;
    unique case (state_q)
      StRun: begin
        if (!stall && enc_valid) begin
          state_d = StEnter;
          code_d  = enc_code;
          epc_d   = (enc_code == CAUSE_SYS) ? pc_in + 32'd4 : pc_in;
          rpc_d   = HANDLER_ADDR;
        end
      end
      StEnter: begin
        state_d = StHandler;
        if (is_int_code(code_q)) begin
          pend_clr = 3'b001 << code_q[1:0];
        end
      end
      StHandler: begin
        if (eret && !stall) begin
          state_d = StLeave;
          rpc_d   = epc_q;
        end
      end
      StLeave: state_d = StRun;
      default: state_d = StRun;
    endcase
    // A new request in the same cycle as the clear keeps the bit pending.
    pend_d = (pend_q & ~pend_clr) | pend_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StRun;
      pend_q       <= 3'b000;
      code_q       <= 3'b000;
      epc_q        <= 32'h0;
      rpc_q        <= 32'h0;
      cause_we_q   <= 1'b0;
      epc_we_q     <= 1'b0;
      flush_q      <= 1'b0;
      redirect_q   <= 1'b0;
      in_handler_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      code_q       <= code_d;
      epc_q        <= epc_d;
      rpc_q        <= rpc_d;
      cause_we_q   <= (state_d == StEnter);
      epc_we_q     <= (state_d == StEnter);
      flush_q      <= (state_d == StEnter) || (state_d == StLeave);
      redirect_q   <= (state_d == StEnter) || (state_d == StLeave);
      in_handler_q <= (state_d == StEnter) || (state_d == StHandler);
    end
  end

  assign cause_we    = cause_we_q;
  assign cause_code  = code_q;
  assign epc_we      = epc_we_q;
  assign epc_out     = epc_q;
  assign flush       = flush_q;
  assign redirect    = redirect_q;
  assign redirect_pc = rpc_q;
  assign in_handler  = in_handler_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: vector table for synchronous exceptions plus
// hand-written interrupt, stall, reset and held-line sequences.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] pc_in;
  logic        exc_ri, exc_ov, exc_sys, eret;
  logic [2:0]  int_req;
  logic        cause_we, epc_we, flush, redirect, in_handler;
  logic [2:0]  cause_code;
  logic [31:0] epc_out, redirect_pc;
  logic [3:0]  strb;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] HADDR = 32'h0000_4180;

  exc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .pc_in       (pc_in),
    .exc_ri      (exc_ri),
    .exc_ov      (exc_ov),
    .exc_sys     (exc_sys),
    .eret        (eret),
    .int_req     (int_req),
    .cause_we    (cause_we),
    .cause_code  (cause_code),
    .epc_we      (epc_we),
    .epc_out     (epc_out),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .in_handler  (in_handler)
  );

  always #5 clk = ~clk;

  assign strb = {cause_we, epc_we, flush, redirect};

  typedef struct {
    logic        ri;
    logic        ov;
    logic        sys;
    logic [31:0] pc;
    logic [2:0]  code;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_enter(input string nm, input logic [2:0] code, input logic [31:0] epc);
    chk({nm, "_strb"}, {28'h0, strb}, 32'hF);
    chk({nm, "_code"}, {29'h0, cause_code}, {29'h0, code});
    chk({nm, "_epc"}, epc_out, epc);
    chk({nm, "_rpc"}, redirect_pc, HADDR);
    chk({nm, "_inh"}, {31'h0, in_handler}, 32'h1);
  endtask

  // eret for one cycle from HANDLER, check LEAVE then RUN.
  task automatic do_leave(input string nm, input logic [31:0] epc);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk({nm, "_lv_strb"}, {28'h0, strb}, 32'h3);
    chk({nm, "_lv_rpc"}, redirect_pc, epc);
    chk({nm, "_lv_inh"}, {31'h0, in_handler}, 32'h0);
    tick();
    chk({nm, "_run_strb"}, {28'h0, strb}, 32'h0);
  endtask

  initial begin
    vecs[0] = '{ri: 0, ov: 1, sys: 0, pc: 32'h0000_0100, code: 3'd3, epc: 32'h0000_0100};
    vecs[1] = '{ri: 1, ov: 0, sys: 1, pc: 32'h0000_0200, code: 3'd5, epc: 32'h0000_0200};
    vecs[2] = '{ri: 0, ov: 0, sys: 1, pc: 32'hFFFF_FFFC, code: 3'd4, epc: 32'h0000_0000};
    vecs[3] = '{ri: 0, ov: 0, sys: 1, pc: 32'h0000_1000, code: 3'd4, epc: 32'h0000_1004};
    vecs[4] = '{ri: 0, ov: 1, sys: 1, pc: 32'h0000_0300, code: 3'd3, epc: 32'h0000_0300};
    vecs[5] = '{ri: 1, ov: 1, sys: 0, pc: 32'h0000_0400, code: 3'd5, epc: 32'h0000_0400};
    vecs[6] = '{ri: 1, ov: 0, sys: 0, pc: 32'hABCD_0000, code: 3'd5, epc: 32'hABCD_0000};

    rst = 1'b1; stall = 1'b0; pc_in = 32'h0; exc_ri = 1'b0; exc_ov = 1'b0;
    exc_sys = 1'b0; eret = 1'b0; int_req = 3'b000;
    #12;
    chk("rst_strb", {28'h0, strb}, 32'h0);
    chk("rst_code", {29'h0, cause_code}, 32'h0);
    chk("rst_epc", epc_out, 32'h0);
    chk("rst_rpc", redirect_pc, 32'h0);
    chk("rst_inh", {31'h0, in_handler}, 32'h0);
    rst = 1'b0;
    tick();
    chk("idle_strb", {28'h0, strb}, 32'h0);

    // Synchronous exception table
    for (int i = 0; i < 7; i++) begin
      exc_ri = vecs[i].ri; exc_ov = vecs[i].ov; exc_sys = vecs[i].sys; pc_in = vecs[i].pc;
      tick();
      exc_ri = 1'b0; exc_ov = 1'b0; exc_sys = 1'b0;
      chk_enter($sformatf("v%0d_ent", i), vecs[i].code, vecs[i].epc);
      tick();
      chk($sformatf("v%0d_hnd_strb", i), {28'h0, strb}, 32'h0);
      chk($sformatf("v%0d_hnd_inh", i), {31'h0, in_handler}, 32'h1);
      chk($sformatf("v%0d_hnd_code", i), {29'h0, cause_code}, {29'h0, vecs[i].code});
      do_leave($sformatf("v%0d", i), vecs[i].epc);
    end

    // Two interrupts: INT1 first, INT2 stays pending until after return
    pc_in = 32'h0000_0500;
    int_req = 3'b110;
    tick();
    int_req = 3'b000;
    chk("int_latch_strb", {28'h0, strb}, 32'h0);
    tick();
    chk_enter("int1", 3'd1, 32'h0000_0500);
    tick();
    tick();
    chk("int1_masked", {28'h0, strb}, 32'h0);
    chk("int1_inh", {31'h0, in_handler}, 32'h1);
    pc_in = 32'h0000_0600;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk("int1_lv_strb", {28'h0, strb}, 32'h3);
    chk("int1_lv_rpc", redirect_pc, 32'h0000_0500);
    tick();
    chk("int1_run_strb", {28'h0, strb}, 32'h0);
    tick();
    chk_enter("int2", 3'd2, 32'h0000_0600);
    tick();
    do_leave("int2", 32'h0000_0600);
    chk("int2_no_reentry", {31'h0, in_handler}, 32'h0);

    // Interrupt raised during HANDLER, then eret together with RI
    pc_in = 32'h0000_0700;
    exc_ov = 1'b1;
    tick();
    exc_ov = 1'b0;
    chk_enter("nest_ov", 3'd3, 32'h0000_0700);
    tick();
    int_req = 3'b001;
    tick();
    int_req = 3'b000;
    tick();
    chk("nest_masked_strb", {28'h0, strb}, 32'h0);
    chk("nest_masked_code", {29'h0, cause_code}, 32'h3);
    pc_in = 32'h0000_0800;
    exc_ri = 1'b1;
    eret = 1'b1;
    tick();
    exc_ri = 1'b0;
    eret = 1'b0;
    chk("eret_ri_strb", {28'h0, strb}, 32'h3);
    chk("eret_ri_rpc", redirect_pc, 32'h0000_0700);
    tick();
    chk("eret_ri_run", {28'h0, strb}, 32'h0);
    tick();
    chk_enter("int0", 3'd0, 32'h0000_0800);
    tick();
    do_leave("int0", 32'h0000_0800);

    // Stall holds off acceptance and blocks eret
    pc_in = 32'h0000_0900;
    exc_ri = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("stall%0d_strb", i), {28'h0, strb}, 32'h0);
      chk($sformatf("stall%0d_inh", i), {31'h0, in_handler}, 32'h0);
    end
    stall = 1'b0;
    tick();
    exc_ri = 1'b0;
    chk_enter("stall_rel", 3'd5, 32'h0000_0900);
    tick();
    stall = 1'b1;
    eret = 1'b1;
    tick();
    chk("stall_eret_strb", {28'h0, strb}, 32'h0);
    chk("stall_eret_inh", {31'h0, in_handler}, 32'h1);
    stall = 1'b0;
    eret = 1'b0;
    do_leave("stall", 32'h0000_0900);

    // Reset during ENTER, with INT1 pending underneath
    pc_in = 32'h0000_0A00;
    exc_ov = 1'b1;
    int_req = 3'b010;
    tick();
    exc_ov = 1'b0;
    int_req = 3'b000;
    chk("pre_rst_strb", {28'h0, strb}, 32'hF);
    rst = 1'b1;
    #1;
    chk("rst_ent_strb", {28'h0, strb}, 32'h0);
    chk("rst_ent_inh", {31'h0, in_handler}, 32'h0);
    chk("rst_ent_rpc", redirect_pc, 32'h0);
    chk("rst_ent_epc", epc_out, 32'h0);
    #10;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_pend%0d", i), {27'h0, strb, in_handler}, 32'h0);
    end

    // int_req[2] held high
    pc_in = 32'h0000_0B00;
    int_req = 3'b100;
    tick();
    chk("hold_latch", {28'h0, strb}, 32'h0);
    tick();
    chk_enter("hold1", 3'd2, 32'h0000_0B00);
    tick();
    do_leave("hold1", 32'h0000_0B00);
    tick();
`ifdef EXC_INT_EDGE_EN
    chk("hold_edge_once", {27'h0, strb, in_handler}, 32'h0);
    int_req = 3'b000;
    tick();
    chk("hold_edge_idle", {31'h0, in_handler}, 32'h0);
`else
    chk_enter("hold2", 3'd2, 32'h0000_0B00);
    int_req = 3'b000;
    tick();
    do_leave("hold2", 32'h0000_0B00);
    tick();
    chk("hold_level_done", {27'h0, strb, in_handler}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
